pi_leaf_port: RTL and testbench
===============================

PI_LEAF_PORT -- requirements
Module: pi_leaf_port

Interface
REQ-001 SHALL have parameter num_leaves, default 2: number of leaves in the tree.
REQ-002 SHALL have parameter payload_sz, default 1: payload bits per packet.
REQ-003 SHALL have parameter addr, default 0: this leaf's address, width a_sz = $clog2(num_leaves).
REQ-004 SHALL have parameter p_sz, default 1+$clog2(num_leaves)+payload_sz: packet size.
REQ-005 SHALL have parameter fifo_depth, default 4: entries per FIFO, a power of two and at least 2.
REQ-006 SHALL have port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port bus_i, input, p_sz: packet from the network switch.
REQ-009 SHALL have port bus_o, output, p_sz: packet to the network switch, registered.
REQ-010 SHALL have port din, input, payload_sz: user transmit payload.
REQ-011 SHALL have port dest, input, a_sz: destination leaf for din.
REQ-012 SHALL have port din_valid, input, 1, and din_ready, output, 1: transmit handshake.
REQ-013 SHALL have port dout, output, payload_sz: received payload.
REQ-014 SHALL have port dout_valid, output, 1, and dout_ready, input, 1: receive handshake.
REQ-015 SHALL have port overflow, output, 1: sticky flag for a dropped receive packet.
REQ-016 SHALL have port drop_cnt, output, 8: saturating count of dropped receive packets.

Function
REQ-017 SHALL use packet format bit p_sz-1 = valid, bits [p_sz-2:payload_sz] = address, bits [payload_sz-1:0] = payload.
REQ-018 SHALL accept a transmit word on any edge where din_valid && din_ready, pushing {dest, din} into the tx FIFO.
REQ-019 SHALL drive din_ready = !tx_full && !reset, independent of a same-cycle pop.
REQ-020 SHALL classify a packet as a bounce when bus_i is valid and its address field != addr.
REQ-021 SHALL, on a bounce, load bus_o with bus_i unchanged at the next edge and SHALL NOT pop the tx FIFO that cycle.
REQ-022 SHALL, with no bounce and a non-empty tx FIFO, pop the head and load bus_o with {1, dest, payload}.
REQ-023 SHALL otherwise load bus_o with all zeros.
REQ-024 SHALL give 1-cycle transmit latency: a handshake at edge N with an empty tx FIFO and no bounce at N+1 gives bus_o valid after edge N+1.
REQ-025 SHALL push the payload into the rx FIFO at the edge when bus_i is valid and its address == addr.
REQ-026 SHALL drop a packet that arrives with the rx FIFO full and no pop in the same cycle, set overflow, and increment drop_cnt saturating at 255.
REQ-027 SHALL accept the push and drop nothing when the rx FIFO is full and a pop occurs in the same cycle.
REQ-028 SHALL make the rx FIFO first-word-fall-through: dout_valid = !rx_empty, dout = head, pop on dout_valid && dout_ready.
REQ-029 SHALL assert dout_valid in the cycle after the edge that sampled the packet when the rx FIFO was empty.
REQ-030 SHALL ignore bus_i entirely when its valid bit is 0, whatever its other bits hold.
REQ-031 SHALL keep both FIFOs in order; pointers wrap modulo fifo_depth; full and empty are told apart by an extra pointer bit.

Reset
REQ-032 SHALL, at the edge where reset=1, clear both FIFOs and set bus_o=0, overflow=0, drop_cnt=0, with din_ready=0 and dout_valid=0 while reset is high.
REQ-033 SHALL discard any in-flight bus_i or din handshake at a reset edge; reset overrides all other events.

Verification
REQ-034 SHALL be verified with num_leaves=4, payload_sz=8, addr=2, p_sz=11 and fifo_depth=4, covering:
- din=0xA5, dest=1, handshake at edge 0 -> bus_o=11'h5A5 for one cycle after edge 1, then 0.
- bus_i=11'h63C for one cycle -> dout=0x3C and dout_valid=1 next cycle; pop with dout_ready=1 -> dout_valid=0.
- tx FIFO holds 0x11 to dest 3 and bus_i=11'h4FF -> bus_o=11'h4FF first, then 11'h711 one cycle later.
- dout_ready=0 and five packets to addr 2 -> first four stored, fifth dropped, overflow=1, drop_cnt=1; drain returns the first four in order.
- four tx words queued with bus_i bouncing every cycle -> din_ready=0; assert reset -> next cycle bus_o=0, FIFOs empty, counters 0.
- bus_i=11'h3FF (valid bit 0) -> no rx push, no bounce, bus_o unaffected.

Source files
------------

// File: rtl/pi_leaf_port.sv
// Leaf port of a packet tree: forwards user words onto the switch, bounces
// foreign packets straight back out, and buffers packets addressed to this leaf.
module pi_leaf_port #(
    parameter int num_leaves = 2,
    parameter int payload_sz = 1,
    parameter int addr       = 0,
    parameter int p_sz       = 1 + $clog2(num_leaves) + payload_sz,
    parameter int fifo_depth = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [p_sz-1:0]               bus_i,
    output logic [p_sz-1:0]               bus_o,
    input  logic [payload_sz-1:0]         din,
    input  logic [$clog2(num_leaves)-1:0] dest,
    input  logic                          din_valid,
    output logic                          din_ready,
    output logic [payload_sz-1:0]         dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic                          overflow,
    output logic [7:0]                    drop_cnt
);

    localparam int A_SZ  = $clog2(num_leaves);
    localparam int IDX_W = $clog2(fifo_depth);
    localparam int PTR_W = IDX_W + 1;
    localparam int TX_W  = A_SZ + payload_sz;
    localparam logic [A_SZ-1:0]  MY_ADDR  = A_SZ'(addr);
    localparam logic [PTR_W-1:0] FULL_XOR = {1'b1, {IDX_W{1'b0}}};

    logic [TX_W-1:0]       tx_mem_q [fifo_depth];
    logic [payload_sz-1:0] rx_mem_q [fifo_depth];
    logic [PTR_W-1:0]      tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
    logic [p_sz-1:0]       bus_o_q, bus_o_d;
    logic                  overflow_q;
    logic [7:0]            drop_cnt_q, drop_cnt_d;

    logic                  tx_full, tx_empty, rx_full, rx_empty;
    logic                  tx_push, tx_pop, rx_push, rx_pop, rx_drop;
    logic                  pkt_valid, bounce, rx_hit;
    logic [A_SZ-1:0]       pkt_addr;
    logic [payload_sz-1:0] pkt_payload;
    logic [TX_W-1:0]       tx_head;

    // Extra MSB on each pointer distinguishes full (MSBs differ) from empty.
    assign tx_full  = (tx_wr_q ^ tx_rd_q) == FULL_XOR;
    assign tx_empty = tx_wr_q == tx_rd_q;
    assign rx_full  = (rx_wr_q ^ rx_rd_q) == FULL_XOR;
    assign rx_empty = rx_wr_q == rx_rd_q;

    assign pkt_valid   = bus_i[p_sz-1];
    assign pkt_addr    = bus_i[p_sz-2:payload_sz];
    assign pkt_payload = bus_i[payload_sz-1:0];
    assign bounce      = pkt_valid && (pkt_addr != MY_ADDR);
    assign rx_hit      = pkt_valid && (pkt_addr == MY_ADDR);

    assign din_ready = !tx_full && !reset;
    assign tx_push   = din_valid && din_ready;
    assign tx_pop    = !bounce && !tx_empty;
    assign tx_head   = tx_mem_q[tx_rd_q[IDX_W-1:0]];

    assign dout_valid = !rx_empty && !reset;
    assign dout       = rx_mem_q[rx_rd_q[IDX_W-1:0]];
    assign rx_pop     = dout_valid && dout_ready;
    // A full rx FIFO still takes a packet when its head leaves on the same edge.
    assign rx_push    = rx_hit && (!rx_full || rx_pop);
    assign rx_drop    = rx_hit && rx_full && !rx_pop;

    always_comb begin
        bus_o_d = '0;
        if (bounce) begin
            bus_o_d = bus_i;
        end else if (tx_pop) begin
            bus_o_d = {1'b1, tx_head};
        end
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (rx_drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wr_q    <= '0;
            tx_rd_q    <= '0;
            rx_wr_q    <= '0;
            rx_rd_q    <= '0;
            bus_o_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            if (tx_push) tx_wr_q <= tx_wr_q + PTR_W'(1);
            if (tx_pop)  tx_rd_q <= tx_rd_q + PTR_W'(1);
            if (rx_push) rx_wr_q <= rx_wr_q + PTR_W'(1);
            if (rx_pop)  rx_rd_q <= rx_rd_q + PTR_W'(1);
            bus_o_q    <= bus_o_d;
            overflow_q <= overflow_q || rx_drop;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem_q[tx_wr_q[IDX_W-1:0]] <= {dest, din};
        end
        if (rx_push && !reset) begin
            rx_mem_q[rx_wr_q[IDX_W-1:0]] <= pkt_payload;
        end
    end

    assign bus_o    = bus_o_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_pi_leaf_port.sv
// Bench for pi_leaf_port (4 leaves, 8-bit payload, address 2, depth 4):
// directed vector table, hand sequences for overflow/saturation/reset, then a random run against a queue model.
module tb_pi_leaf_port;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] bus_i;
    logic [10:0] bus_o;
    logic [7:0]  din;
    logic [1:0]  dest;
    logic        din_valid;
    logic        din_ready;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        overflow;
    logic [7:0]  drop_cnt;

    int total = 0;
    int bad   = 0;

    pi_leaf_port #(
        .num_leaves(4), .payload_sz(8), .addr(2), .p_sz(11), .fifo_depth(4)
    ) dut (
        .clk(clk), .reset(reset), .bus_i(bus_i), .bus_o(bus_o),
        .din(din), .dest(dest), .din_valid(din_valid), .din_ready(din_ready),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [10:0] bus;
        logic [7:0]  d;
        logic [1:0]  dst;
        logic        dv;
        logic        drdy;
        logic [10:0] e_bus;
        logic        e_dval;
        logic [7:0]  e_dout;
        logic        e_rdy;
        logic        e_ov;
        logic [7:0]  e_dc;
    } vec_t;

    vec_t tbl [13];

    // Reference model state
    logic [9:0]  m_tx [$];
    logic [7:0]  m_rx [$];
    logic [10:0] m_bus;
    logic        m_ov;
    int          m_dc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [10:0] b, input logic [7:0] d,
                         input logic [1:0] ds, input logic dv, input logic dr);
        reset = r; bus_i = b; din = d; dest = ds; din_valid = dv; dout_ready = dr;
    endtask

    // Advance the model across one edge using the inputs currently applied.
    task automatic model_edge();
        logic hit, bnc, rxpop, txpush, txpop;
        int   rxsz;
        if (reset) begin
            m_tx.delete(); m_rx.delete();
            m_bus = '0; m_ov = 1'b0; m_dc = 0;
        end else begin
            hit    = bus_i[10] && (bus_i[9:8] == 2'd2);
            bnc    = bus_i[10] && (bus_i[9:8] != 2'd2);
            rxpop  = (m_rx.size() > 0) && dout_ready;
            txpush = din_valid && (m_tx.size() < 4);
            txpop  = !bnc && (m_tx.size() > 0);
            rxsz   = m_rx.size();
            if (bnc)        m_bus = bus_i;
            else if (txpop) m_bus = {1'b1, m_tx.pop_front()};
            else            m_bus = '0;
            if (txpush) m_tx.push_back({dest, din});
            if (rxpop) void'(m_rx.pop_front());
            if (hit) begin
                if (rxsz < 4 || rxpop) m_rx.push_back(bus_i[7:0]);
                else begin
                    m_ov = 1'b1;
                    if (m_dc < 255) m_dc++;
                end
            end
        end
    endtask

    task automatic model_check();
        logic e_dv;
        e_dv = !reset && (m_rx.size() > 0);
        chk("rnd_bus_o", 32'(bus_o), 32'(m_bus));
        chk("rnd_dout_valid", 32'(dout_valid), 32'(e_dv));
        if (e_dv) chk("rnd_dout", 32'(dout), 32'(m_rx[0]));
        chk("rnd_din_ready", 32'(din_ready), 32'(!reset && (m_tx.size() < 4)));
        chk("rnd_overflow", 32'(overflow), 32'(m_ov));
        chk("rnd_drop_cnt", 32'(drop_cnt), 32'(m_dc));
    endtask

    initial begin
        drive(1'b1, '0, '0, '0, 1'b0, 1'b0);

        //          rst bus     din    dst  dv  rdy  e_bus   e_dv e_dout e_rdy e_ov e_dc
        tbl[0]  = '{1, 11'h000, 8'h00, 2'd0, 0, 0, 11'h000, 0, 8'h00, 0, 0, 8'd0};
        tbl[1]  = '{0, 11'h000, 8'hA5, 2'd1, 1, 0, 11'h000, 0, 8'h00, 1, 0, 8'd0};
        tbl[2]  = '{0, 11'h000, 8'h00, 2'd0, 0, 0, 11'h5A5, 0, 8'h00, 1, 0, 8'd0};
        tbl[3]  = '{0, 11'h000, 8'h00, 2'd0, 0, 0, 11'h000, 0, 8'h00, 1, 0, 8'd0};
        tbl[4]  = '{0, 11'h63C, 8'h00, 2'd0, 0, 0, 11'h000, 1, 8'h3C, 1, 0, 8'd0};
        tbl[5]  = '{0, 11'h000, 8'h00, 2'd0, 0, 1, 11'h000, 0, 8'h00, 1, 0, 8'd0};
        tbl[6]  = '{0, 11'h000, 8'h11, 2'd3, 1, 0, 11'h000, 0, 8'h00, 1, 0, 8'd0};
        tbl[7]  = '{0, 11'h4FF, 8'h00, 2'd0, 0, 0, 11'h4FF, 0, 8'h00, 1, 0, 8'd0};
        tbl[8]  = '{0, 11'h000, 8'h00, 2'd0, 0, 0, 11'h711, 0, 8'h00, 1, 0, 8'd0};
        tbl[9]  = '{0, 11'h3FF, 8'h00, 2'd0, 0, 0, 11'h000, 0, 8'h00, 1, 0, 8'd0};
        tbl[10] = '{0, 11'h3FF, 8'h22, 2'd0, 1, 0, 11'h000, 0, 8'h00, 1, 0, 8'd0};
        tbl[11] = '{0, 11'h3FF, 8'h00, 2'd0, 0, 0, 11'h422, 0, 8'h00, 1, 0, 8'd0};
        tbl[12] = '{0, 11'h000, 8'h00, 2'd0, 0, 0, 11'h000, 0, 8'h00, 1, 0, 8'd0};

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].rst, tbl[i].bus, tbl[i].d, tbl[i].dst, tbl[i].dv, tbl[i].drdy);
            step();
            chk($sformatf("vec%0d_bus_o", i), 32'(bus_o), 32'(tbl[i].e_bus));
            chk($sformatf("vec%0d_dout_valid", i), 32'(dout_valid), 32'(tbl[i].e_dval));
            if (tbl[i].e_dval) chk($sformatf("vec%0d_dout", i), 32'(dout), 32'(tbl[i].e_dout));
            chk($sformatf("vec%0d_din_ready", i), 32'(din_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(tbl[i].e_ov));
            chk($sformatf("vec%0d_drop_cnt", i), 32'(drop_cnt), 32'(tbl[i].e_dc));
        end

        // Rx overflow: five packets with no reader, then drain with a push on a full+pop edge.
        for (int k = 1; k <= 5; k++) begin
            drive(1'b0, 11'h600 | 11'(k), '0, '0, 1'b0, 1'b0);
            step();
        end
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_drop_cnt", 32'(drop_cnt), 32'd1);
        begin
            logic [7:0] exp_order [5];
            exp_order = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h06};
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("drain%0d_valid", k), 32'(dout_valid), 32'd1);
                chk($sformatf("drain%0d_dout", k), 32'(dout), 32'(exp_order[k]));
                drive(1'b0, (k == 0) ? 11'h606 : 11'h000, '0, '0, 1'b0, 1'b1);
                step();
            end
        end
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        chk("drain_empty", 32'(dout_valid), 32'd0);
        chk("drain_drop_cnt", 32'(drop_cnt), 32'd1);

        // Tx fills while every cycle bounces; reset then discards in-flight traffic.
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 11'h4FF, 8'(8'h30 + k), 2'd1, 1'b1, 1'b0);
            step();
        end
        drive(1'b0, 11'h4FF, 8'h40, 2'd1, 1'b1, 1'b0);
        chk("txfull_din_ready", 32'(din_ready), 32'd0);
        chk("txfull_bus_o", 32'(bus_o), 32'h4FF);
        drive(1'b1, 11'h63C, 8'h41, 2'd1, 1'b1, 1'b0);
        step();
        chk("rst_bus_o", 32'(bus_o), 32'd0);
        chk("rst_din_ready", 32'(din_ready), 32'd0);
        chk("rst_dout_valid", 32'(dout_valid), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        step();
        chk("post_rst_bus_o", 32'(bus_o), 32'd0);
        chk("post_rst_din_ready", 32'(din_ready), 32'd1);
        chk("post_rst_dout_valid", 32'(dout_valid), 32'd0);

        // Drop counter saturation: 4 stored, then 256 drops.
        for (int k = 0; k < 260; k++) begin
            drive(1'b0, 11'h600 | 11'(k & 8'hFF), '0, '0, 1'b0, 1'b0);
            step();
            if (k == 257) chk("sat_254", 32'(drop_cnt), 32'd254);
            if (k == 258) chk("sat_255", 32'(drop_cnt), 32'd255);
        end
        chk("sat_hold", 32'(drop_cnt), 32'd255);
        chk("sat_overflow", 32'(overflow), 32'd1);

        // Random traffic against the queue model.
        drive(1'b1, '0, '0, '0, 1'b0, 1'b0);
        model_edge();
        step();
        model_check();
        for (int c = 0; c < 1500; c++) begin
            int kind;
            logic [10:0] b;
            kind = int'($urandom_range(0, 3));
            case (kind)
                0: b = '0;
                1: b = {1'b1, 2'd2, 8'($urandom)};
                2: b = {1'b1, 2'($urandom_range(0, 3)) ^ ((($urandom & 1) == 0) ? 2'd0 : 2'd0), 8'($urandom)};
                default: b = {1'b0, 10'($urandom)};
            endcase
            drive(($urandom_range(0, 99) == 0),
                  b, 8'($urandom), 2'($urandom), 1'($urandom),
                  ((c / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
            model_edge();
            step();
            model_check();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
